// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between two masters,
// with lock for atomic read-modify-write, lock timeout and address range check.
module dmem_arbiter #(
  parameter int DEPTH    = 256,
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic        r0_lock,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic        r1_lock,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

  localparam int               CNT_W    = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
  localparam logic [31:0]      ADDR_LIM = 32'(DEPTH);

  state_t           state, state_nxt;
  logic             last;
  logic [CNT_W-1:0] lock_cnt;
  logic             timeout;
  logic             gnt0, gnt1, any_gnt;
  logic             sel_we;
  logic [31:0]      sel_addr, sel_wdata;
  logic             addr_ok;
  logic [31:0]      rd_word;

  logic [1:0]       vld_p1;
  logic [31:0]      rdata0_p1, rdata1_p1;
  logic             err0_p1, err1_p1;

  // Stage p0: grant decision, next state and memory drive, all combinational
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    timeout   = (state != IDLE) && (lock_cnt == CNT_LAST);
    case (state)
      IDLE: begin
        gnt0 = r0_req && (!r1_req || last);
        gnt1 = r1_req && (!r0_req || !last);
        if (gnt0 && r0_lock)      state_nxt = LOCK0;
        else if (gnt1 && r1_lock) state_nxt = LOCK1;
      end
      LOCK0: begin
        gnt0 = r0_req;
        if (timeout || (gnt0 && !r0_lock)) state_nxt = IDLE;
      end
      LOCK1: begin
        gnt1 = r1_req;
        if (timeout || (gnt1 && !r1_lock)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Grants and memory strobes must be quiet while reset is held.
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    any_gnt   = gnt0 || gnt1;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt0) begin
      sel_we    = r0_we;
      sel_addr  = r0_addr;
      sel_wdata = r0_wdata;
    end else if (gnt1) begin
      sel_we    = r1_we;
      sel_addr  = r1_addr;
      sel_wdata = r1_wdata;
    end
    addr_ok   = sel_addr < ADDR_LIM;
    mem_addr  = sel_addr;
    mem_wdata = sel_wdata;
    mem_write = any_gnt && sel_we && addr_ok;
    mem_read  = any_gnt && !sel_we && addr_ok;
    rd_word   = mem_read ? mem_rdata : '0;
  end

  assign r0_gnt = gnt0;
  assign r1_gnt = gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (gnt0)      last <= 1'b0;
      else if (gnt1) last <= 1'b1;
      // Counts cycles of an ongoing lock; any entry or exit restarts it.
      if ((state != IDLE) && (state_nxt == state)) lock_cnt <= lock_cnt + 1'b1;
      else                                         lock_cnt <= '0;
    end
  end

  // Stage p1: registered response, one cycle after the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= '0;
      rdata0_p1 <= '0;
      rdata1_p1 <= '0;
      err0_p1   <= 1'b0;
      err1_p1   <= 1'b0;
    end else begin
      vld_p1 <= {gnt1, gnt0};
      if (gnt0) begin
        rdata0_p1 <= rd_word;
        err0_p1   <= !addr_ok;
      end
      if (gnt1) begin
        rdata1_p1 <= rd_word;
        err1_p1   <= !addr_ok;
      end
    end
  end

  assign r0_rvalid = vld_p1[0];
  assign r1_rvalid = vld_p1[1];
  assign r0_rdata  = rdata0_p1;
  assign r1_rdata  = rdata1_p1;
  assign r0_err    = err0_p1;
  assign r1_err    = err1_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table plus lock/timeout/reset sequences,
// with a response scoreboard and a behavioural model of the data memory.
module tb_dmem_arbiter;
  localparam int DEPTH    = 256;
  localparam int LOCK_MAX = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r0_we, r0_lock, r0_gnt, r0_rvalid, r0_err;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_lock, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  // Memory model: address wraps, read data is always presented.
  logic [31:0] dmem [0:DEPTH-1];
  logic        mem_init;
  assign mem_rdata = dmem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) dmem[i] <= init_val(i);
    end else if (mem_write) begin
      dmem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  typedef struct {
    logic        req0, we0, lock0;
    logic [31:0] addr0, wdata0;
    logic        req1, we1, lock1;
    logic [31:0] addr1, wdata1;
    logic        eg0, eg1;
  } vec_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        sb[$];
  vec_t        tbl[$];
  logic [31:0] ref_mem [0:DEPTH-1];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic vec_t mk(input int q0, w0, l0, a0, d0,
                              input int q1, w1, l1, a1, d1,
                              input int e0, e1);
    vec_t v;
    v.req0 = (q0 != 0); v.we0 = (w0 != 0); v.lock0 = (l0 != 0);
    v.addr0 = 32'(a0);  v.wdata0 = 32'(d0);
    v.req1 = (q1 != 0); v.we1 = (w1 != 0); v.lock1 = (l1 != 0);
    v.addr1 = 32'(a1);  v.wdata1 = 32'(d1);
    v.eg0 = (e0 != 0);  v.eg1 = (e1 != 0);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    r0_req = v.req0; r0_we = v.we0; r0_lock = v.lock0; r0_addr = v.addr0; r0_wdata = v.wdata0;
    r1_req = v.req1; r1_we = v.we1; r1_lock = v.lock1; r1_addr = v.addr1; r1_wdata = v.wdata1;
  endtask

  task automatic check_rsp();
    rsp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port == 0) begin
        chk("r0_rvalid", 32'(r0_rvalid), 32'd1);
        chk("r1_rvalid quiet", 32'(r1_rvalid), 32'd0);
        chk("r0_rdata", r0_rdata, e.rdata);
        chk("r0_err", 32'(r0_err), 32'(e.err));
      end else begin
        chk("r1_rvalid", 32'(r1_rvalid), 32'd1);
        chk("r0_rvalid quiet", 32'(r0_rvalid), 32'd0);
        chk("r1_rdata", r1_rdata, e.rdata);
        chk("r1_err", 32'(r1_err), 32'(e.err));
      end
    end else begin
      chk("r0_rvalid idle", 32'(r0_rvalid), 32'd0);
      chk("r1_rvalid idle", 32'(r1_rvalid), 32'd0);
    end
  endtask

  // One cycle: check last cycle's response, apply inputs, check grant and memory drive.
  task automatic step(input vec_t v);
    logic [31:0] a, wd;
    logic        we, any;
    rsp_t        e;
    @(negedge clk);
    check_rsp();
    drive(v);
    #1;
    chk("r0_gnt", 32'(r0_gnt), 32'(v.eg0));
    chk("r1_gnt", 32'(r1_gnt), 32'(v.eg1));
    any = v.eg0 || v.eg1;
    a = '0; wd = '0; we = 1'b0;
    if (v.eg0) begin
      a = v.addr0; wd = v.wdata0; we = v.we0;
    end else if (v.eg1) begin
      a = v.addr1; wd = v.wdata1; we = v.we1;
    end
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_wdata, wd);
    chk("mem_write", 32'(mem_write), 32'(any && we && (a < 32'(DEPTH))));
    chk("mem_read", 32'(mem_read), 32'(any && !we && (a < 32'(DEPTH))));
    if (any) begin
      e.port  = v.eg0 ? 0 : 1;
      e.err   = (a >= 32'(DEPTH));
      e.rdata = '0;
      if (!e.err && !we) e.rdata = ref_mem[a[7:0]];
      if (!e.err && we)  ref_mem[a[7:0]] = wd;
      sb.push_back(e);
    end
  endtask

  // Assert reset mid-cycle while both masters request, then release with masters idle.
  task automatic reset_pulse();
    @(negedge clk);
    drive(mk(1, 0, 0, 7, 0, 1, 0, 0, 8, 0, 0, 0));
    rst_n = 1'b0;
    #1;
    chk("rst r0_rvalid", 32'(r0_rvalid), 32'd0);
    chk("rst r1_rvalid", 32'(r1_rvalid), 32'd0);
    chk("rst r0_gnt", 32'(r0_gnt), 32'd0);
    chk("rst r1_gnt", 32'(r1_gnt), 32'd0);
    chk("rst mem_read", 32'(mem_read), 32'd0);
    sb.delete();
    @(negedge clk);
    chk("rst held r0_gnt", 32'(r0_gnt), 32'd0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    rst_n    = 1'b0;
    mem_init = 1'b1;
    drive(mk(1, 0, 0, 5, 32'h55, 1, 1, 0, 6, 32'h66, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset r0_gnt", 32'(r0_gnt), 32'd0);
    chk("reset r1_gnt", 32'(r1_gnt), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset mem_write", 32'(mem_write), 32'd0);
    chk("reset mem_read", 32'(mem_read), 32'd0);
    chk("reset r0_rvalid", 32'(r0_rvalid), 32'd0);
    chk("reset r1_rvalid", 32'(r1_rvalid), 32'd0);
    chk("reset r0_rdata", r0_rdata, 32'd0);
    chk("reset r1_rdata", r1_rdata, 32'd0);
    chk("reset r0_err", 32'(r0_err), 32'd0);
    chk("reset r1_err", 32'(r1_err), 32'd0);
    mem_init = 1'b0;
    drive(idle);
    rst_n = 1'b1;

    // contention after reset: r0, r1, r0, r1
    tbl.push_back(mk(1, 0, 0, 10, 0, 1, 0, 0, 20, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 11, 0, 1, 0, 0, 20, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 11, 0, 1, 0, 0, 21, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 12, 0, 1, 0, 0, 21, 0, 0, 1));
    // single write then read back
    tbl.push_back(mk(1, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0));
    // out of range write, address 0 untouched, out of range read
    tbl.push_back(mk(1, 1, 0, 256, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 0, 0, 1));
    // lock: r1 read-modify-write on address 9 while r0 keeps asking
    tbl.push_back(mk(1, 0, 0, 31, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 30, 0, 1, 0, 1, 9, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 30, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 30, 0, 1, 1, 0, 9, 32'h12345678, 0, 1));
    tbl.push_back(mk(1, 0, 0, 30, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 9, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(idle);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // lock timeout: r1 locks then goes silent, r0 waits LOCK_MAX cycles
    step(mk(0, 0, 0, 0, 0, 1, 0, 1, 40, 0, 0, 1));
    for (int k = 1; k <= LOCK_MAX; k++) step(mk(1, 0, 0, 50, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 50, 0, 0, 0, 0, 0, 0, 1, 0));
    step(idle);

    // forced unlock: r1 keeps re-locking, the lock still ends after LOCK_MAX cycles
    step(mk(0, 0, 0, 0, 0, 1, 0, 1, 41, 0, 0, 1));
    for (int k = 1; k <= LOCK_MAX; k++) step(mk(1, 0, 0, 51, 0, 1, 0, 1, 41 + k, 0, 0, 1));
    step(mk(1, 0, 0, 51, 0, 1, 0, 1, 41, 0, 1, 0));
    step(idle);

    // reset in LOCK0: pending response dropped, r1 alone is then granted
    step(mk(1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0));
    reset_pulse();
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 8, 0, 0, 1));
    step(idle);

    // reset in LOCK0 after an r0 win: r0 still wins the first tie afterwards
    step(mk(1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0));
    reset_pulse();
    step(mk(1, 0, 0, 7, 0, 1, 0, 0, 8, 0, 1, 0));
    step(idle);
    step(idle);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
